// File: rtl/snoop_responder.sv
// snoop_responder
//   Bus-side MSI snoop controller. It holds the per-line status/tag table
//   that the processor-side issuer reads as old_Status. It accepts snooped
//   bus messages over a valid/ready handshake, downgrades or invalidates
//   matching lines, and requests a writeback when a line held in M is hit
//   by another cache's read_miss or write_miss.
//
// Encodings (shared with the issuer)
//   status : I=00 S=01 M=10 (11 is treated as I and never hits)
//   message: write_miss=00 read_miss=01 invalidate=10 NA=11
//
// Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   loc_we/index/tag/status  issuer write into the table (applies in any state)
//   rd_index -> rd_status/rd_tag  combinational table read for the issuer
//   bus_valid/message/index/tag, bus_ready  snooped message handshake
//   wb_req/index/tag, wb_ack  writeback request, held until wb_ack is sampled
//   abort_access          1-cycle pulse: bus access hit a local M line
//   snoop_done            1-cycle pulse: table update for the message commits
//   proto_err             1-cycle pulse: invalidate hit a local M line
//   dbg_state             current FSM state (IDLE=0 LOOKUP=1 WB=2 UPDATE=3)
//
// Handshake: a message transfers on a rising edge where bus_valid and
// bus_ready are both 1. bus_ready depends only on the FSM state, loc_we and
// reset, never on bus_valid. Once accepted, message/index/tag are registered
// and the bus side may change freely.
module snoop_responder #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loc_we,
  input  logic [IDX_W-1:0] loc_index,
  input  logic [TAG_W-1:0] loc_tag,
  input  logic [1:0]       loc_status,
  input  logic [IDX_W-1:0] rd_index,
  output logic [1:0]       rd_status,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             bus_valid,
  input  logic [1:0]       bus_message,
  input  logic [IDX_W-1:0] bus_index,
  input  logic [TAG_W-1:0] bus_tag,
  output logic             bus_ready,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_index,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_ack,
  output logic             abort_access,
  output logic             snoop_done,
  output logic             proto_err,
  output logic [1:0]       dbg_state
);

  localparam int LINES = 1 << IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  localparam logic [1:0] MSG_WM  = 2'b00;
  localparam logic [1:0] MSG_RM  = 2'b01;
  localparam logic [1:0] MSG_INV = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WB     = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       status_q [LINES];
  logic [1:0]       status_d [LINES];
  logic [TAG_W-1:0] tag_q    [LINES];
  logic [TAG_W-1:0] tag_d    [LINES];

  // Registered copy of the accepted message.
  logic [1:0]       req_msg_q, req_msg_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;

  // Snoop result decided in LOOKUP and committed in UPDATE, so a local write
  // to the same line during LOOKUP/WB is overridden by the snoop.
  logic             upd_en_q, upd_en_d;
  logic [1:0]       new_status_q, new_status_d;

  logic       accept;
  logic [1:0] line_status;
  logic       line_valid;
  logic       hit;
  logic       m_hit;
  logic       m_hit_access;

  assign accept      = bus_valid && bus_ready;
  assign line_status = status_q[req_idx_q];
  // Status 11 is not a valid state and is never counted as a hit.
  assign line_valid  = (line_status == ST_S) || (line_status == ST_M);
  assign hit         = line_valid && (tag_q[req_idx_q] == req_tag_q);
  assign m_hit       = hit && (line_status == ST_M);
  assign m_hit_access = m_hit && ((req_msg_q == MSG_RM) || (req_msg_q == MSG_WM));

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    tag_d        = tag_q;
    req_msg_d    = req_msg_q;
    req_idx_d    = req_idx_q;
    req_tag_d    = req_tag_q;
    upd_en_d     = upd_en_q;
    new_status_d = new_status_q;

    if (loc_we) begin
      status_d[loc_index] = loc_status;
      tag_d[loc_index]    = loc_tag;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_msg_d = bus_message;
          req_idx_d = bus_index;
          req_tag_d = bus_tag;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        upd_en_d     = 1'b0;
        new_status_d = line_status;
        if (hit) begin
          case (req_msg_q)
            MSG_RM: begin
              upd_en_d     = 1'b1;
              new_status_d = ST_S;
            end
            MSG_WM: begin
              upd_en_d     = 1'b1;
              new_status_d = ST_I;
            end
            MSG_INV: begin
              // Invalidate on an M line is illegal and leaves it untouched.
              upd_en_d     = (line_status == ST_S);
              new_status_d = ST_I;
            end
            default: upd_en_d = 1'b0;
          endcase
        end
        state_d = m_hit_access ? WB : UPDATE;
      end
      WB: begin
        if (wb_ack) state_d = UPDATE;
      end
      UPDATE: begin
        // Snoop result takes priority over a same-cycle local write.
        if (upd_en_q) status_d[req_idx_q] = new_status_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_msg_q    <= '0;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
      upd_en_q     <= 1'b0;
      new_status_q <= ST_I;
      for (int i = 0; i < LINES; i++) begin
        status_q[i] <= ST_I;
        tag_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      req_msg_q    <= req_msg_d;
      req_idx_q    <= req_idx_d;
      req_tag_q    <= req_tag_d;
      upd_en_q     <= upd_en_d;
      new_status_q <= new_status_d;
      status_q     <= status_d;
      tag_q        <= tag_d;
    end
  end

  // Outputs are gated by reset so wb_req and the pulses drop in the reset
  // cycle itself rather than one cycle later.
  assign bus_ready    = (state_q == IDLE) && !loc_we && !reset;
  assign wb_req       = (state_q == WB) && !reset;
  assign wb_index     = req_idx_q;
  assign wb_tag       = req_tag_q;
  assign abort_access = (state_q == LOOKUP) && m_hit_access && !reset;
  assign proto_err    = (state_q == LOOKUP) && m_hit && (req_msg_q == MSG_INV) && !reset;
  assign snoop_done   = (state_q == UPDATE) && !reset;
  assign rd_status    = status_q[rd_index];
  assign rd_tag       = tag_q[rd_index];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_snoop_responder.sv
module tb_snoop_responder;

  logic       clock;
  logic       reset;
  logic       loc_we;
  logic [1:0] loc_index;
  logic [3:0] loc_tag;
  logic [1:0] loc_status;
  logic [1:0] rd_index;
  logic [1:0] rd_status;
  logic [3:0] rd_tag;
  logic       bus_valid;
  logic [1:0] bus_message;
  logic [1:0] bus_index;
  logic [3:0] bus_tag;
  logic       bus_ready;
  logic       wb_req;
  logic [1:0] wb_index;
  logic [3:0] wb_tag;
  logic       wb_ack;
  logic       abort_access;
  logic       snoop_done;
  logic       proto_err;
  logic [1:0] dbg_state;

  snoop_responder #(.IDX_W(2), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .loc_we(loc_we), .loc_index(loc_index), .loc_tag(loc_tag), .loc_status(loc_status),
    .rd_index(rd_index), .rd_status(rd_status), .rd_tag(rd_tag),
    .bus_valid(bus_valid), .bus_message(bus_message), .bus_index(bus_index), .bus_tag(bus_tag),
    .bus_ready(bus_ready),
    .wb_req(wb_req), .wb_index(wb_index), .wb_tag(wb_tag), .wb_ack(wb_ack),
    .abort_access(abort_access), .snoop_done(snoop_done), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    loc_we = 0; loc_index = 0; loc_tag = 0; loc_status = 0;
    bus_valid = 0; bus_message = 0; bus_index = 0; bus_tag = 0; wb_ack = 0;
  endtask

  task automatic loc_write(input logic [1:0] idx, input logic [3:0] tg, input logic [1:0] st);
    @(negedge clock);
    loc_we = 1; loc_index = idx; loc_tag = tg; loc_status = st;
    @(negedge clock);
    loc_we = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  typedef struct {
    logic [1:0] idx;
    logic [3:0] ltag;
    logic [1:0] lstat;
    logic [1:0] msg;
    logic [3:0] btag;
    logic [1:0] exp_stat;
    logic       exp_wb;
    logic       exp_abort;
    logic       exp_perr;
  } vec_t;

  // Sends one message already set up on the bus at a negedge, services any
  // writeback after 4 cycles of wb_req, and checks pulses and timing.
  task automatic run_snoop(input vec_t v, input string tag_s);
    int  cyc;
    int  wb_cnt;
    int  done_cyc;
    logic saw_abort, saw_perr, saw_wb;
    logic [1:0] exp_s;
    cyc = 0; wb_cnt = 0; done_cyc = -1;
    saw_abort = 0; saw_perr = 0; saw_wb = 0;
    bus_valid = 1; bus_message = v.msg; bus_index = v.idx; bus_tag = v.btag;
    exp_q.push_back(v.exp_stat);
    #1 check({tag_s, " bus_ready"}, {31'd0, bus_ready}, 32'd1);
    while (cyc < 20 && done_cyc < 0) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      bus_valid = 0;
      wb_ack = 0;
      if (abort_access) begin
        saw_abort = 1;
        check({tag_s, " abort_cycle"}, cyc, 1);
      end
      if (proto_err) begin
        saw_perr = 1;
        check({tag_s, " perr_cycle"}, cyc, 1);
      end
      if (wb_req) begin
        saw_wb = 1;
        wb_cnt++;
        if (wb_cnt == 1) begin
          check({tag_s, " wb_index"}, {30'd0, wb_index}, {30'd0, v.idx});
          check({tag_s, " wb_tag"}, {28'd0, wb_tag}, {28'd0, v.btag});
        end
        if (wb_cnt == 4) wb_ack = 1;
      end
      if (snoop_done) done_cyc = cyc;
    end
    check({tag_s, " done_seen"}, {31'd0, done_cyc >= 0}, 32'd1);
    if (!v.exp_wb) check({tag_s, " done_latency"}, done_cyc, 2);
    else check({tag_s, " wb_cycles"}, wb_cnt, 4);
    check({tag_s, " wb_seen"}, {31'd0, saw_wb}, {31'd0, v.exp_wb});
    check({tag_s, " abort_seen"}, {31'd0, saw_abort}, {31'd0, v.exp_abort});
    check({tag_s, " perr_seen"}, {31'd0, saw_perr}, {31'd0, v.exp_perr});
    // New status is visible the cycle after snoop_done.
    @(negedge clock);
    rd_index = v.idx;
    #1;
    exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
    check({tag_s, " rd_status"}, {30'd0, rd_status}, {30'd0, exp_s});
    check({tag_s, " rd_tag"}, {28'd0, rd_tag}, {28'd0, v.ltag});
  endtask

  vec_t vecs[11];

  initial begin
    vec_t v;
    logic wb_seen;
    reset = 1;
    rd_index = 0;
    idle_inputs();

    //            idx  ltag  lstat  msg    btag  exp   wb abort perr
    vecs[0]  = '{2'd2, 4'h5, 2'b01, 2'b01, 4'h5, 2'b01, 0, 0, 0};
    vecs[1]  = '{2'd1, 4'h3, 2'b10, 2'b00, 4'h3, 2'b00, 1, 1, 0};
    vecs[2]  = '{2'd0, 4'h7, 2'b01, 2'b10, 4'h6, 2'b01, 0, 0, 0};
    vecs[3]  = '{2'd0, 4'h7, 2'b01, 2'b10, 4'h7, 2'b00, 0, 0, 0};
    vecs[4]  = '{2'd3, 4'h9, 2'b10, 2'b01, 4'h9, 2'b01, 1, 1, 0};
    vecs[5]  = '{2'd3, 4'h9, 2'b10, 2'b10, 4'h9, 2'b10, 0, 0, 1};
    vecs[6]  = '{2'd2, 4'h4, 2'b01, 2'b00, 4'h4, 2'b00, 0, 0, 0};
    vecs[7]  = '{2'd1, 4'hA, 2'b10, 2'b11, 4'hA, 2'b10, 0, 0, 0};
    vecs[8]  = '{2'd1, 4'h2, 2'b11, 2'b01, 4'h2, 2'b11, 0, 0, 0};
    vecs[9]  = '{2'd0, 4'hF, 2'b10, 2'b01, 4'hE, 2'b10, 0, 0, 0};
    vecs[10] = '{2'd2, 4'h1, 2'b00, 2'b00, 4'h1, 2'b00, 0, 0, 0};

    // Reset state: bus_ready low during reset, table clear right after.
    repeat (3) @(negedge clock);
    #1 check("ready_in_reset", {31'd0, bus_ready}, 32'd0);
    reset = 0;
    #1 check("ready_after_reset", {31'd0, bus_ready}, 32'd1);
    check("state_after_reset", {30'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_index = i[1:0];
      #1;
      check("reset_status", {30'd0, rd_status}, 32'd0);
      check("reset_tag", {28'd0, rd_tag}, 32'd0);
    end
    check("reset_wb_req", {31'd0, wb_req}, 32'd0);

    // Table-driven transitions.
    for (int i = 0; i < 11; i++) begin
      loc_write(vecs[i].idx, vecs[i].ltag, vecs[i].lstat);
      run_snoop(vecs[i], $sformatf("vec%0d", i));
    end

    // Local write concurrent with bus_valid stalls acceptance one cycle;
    // then invalidate on M gives proto_err and status stays M.
    @(negedge clock);
    loc_we = 1; loc_index = 3; loc_tag = 4'h2; loc_status = 2'b10;
    bus_valid = 1; bus_message = 2'b10; bus_index = 3; bus_tag = 4'h2;
    #1 check("conc_ready_low", {31'd0, bus_ready}, 32'd0);
    @(negedge clock);
    loc_we = 0;
    check("conc_not_accepted", {30'd0, dbg_state}, 32'd0);
    v = '{2'd3, 4'h2, 2'b10, 2'b10, 4'h2, 2'b10, 0, 0, 1};
    run_snoop(v, "conc");

    // Snoop wins: local write to the same line while in LOOKUP.
    loc_write(2'd1, 4'h6, 2'b01);
    @(negedge clock);
    bus_valid = 1; bus_message = 2'b00; bus_index = 1; bus_tag = 4'h6;
    exp_q.push_back(2'b00);
    @(negedge clock);
    bus_valid = 0;
    check("win_in_lookup", {30'd0, dbg_state}, 32'd1);
    loc_we = 1; loc_index = 1; loc_tag = 4'h6; loc_status = 2'b10;
    @(negedge clock);
    loc_we = 0;
    check("win_done", {31'd0, snoop_done}, 32'd1);
    @(negedge clock);
    rd_index = 1;
    #1 check("win_status", {30'd0, rd_status}, {30'd0, exp_q.pop_front()});

    // wb_ack while idle is ignored.
    @(negedge clock);
    wb_ack = 1;
    @(negedge clock);
    wb_ack = 0;
    check("stray_ack_state", {30'd0, dbg_state}, 32'd0);
    check("stray_ack_wb", {31'd0, wb_req}, 32'd0);

    // Reset while wb_req is high.
    loc_write(2'd0, 4'hC, 2'b10);
    @(negedge clock);
    bus_valid = 1; bus_message = 2'b01; bus_index = 0; bus_tag = 4'hC;
    wb_seen = 0;
    for (int k = 0; k < 10 && !wb_seen; k++) begin
      @(negedge clock);
      bus_valid = 0;
      if (wb_req) wb_seen = 1;
    end
    check("rst_wb_seen", {31'd0, wb_seen}, 32'd1);
    reset = 1;
    #1 check("rst_wb_drop", {31'd0, wb_req}, 32'd0);
    @(negedge clock);
    reset = 0;
    #1;
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_wb_after", {31'd0, wb_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_index = i[1:0];
      #1 check("rst_lines", {30'd0, rd_status}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
